// File: rtl/reg_file_8bit_if.sv
// ----------------------------------------------------------------------------
// reg_file_8bit_if : read/write/debug port bundle for the MIPS register file
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface reg_file_8bit_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] rd_addr1;
  logic [ADDR_WIDTH-1:0] rd_addr2;
  logic [DATA_WIDTH-1:0] rd_data1;
  logic [DATA_WIDTH-1:0] rd_data2;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  reg_write;
  logic [ADDR_WIDTH-1:0] dbg_addr;
  logic [DATA_WIDTH-1:0] dbg_data;

  modport master (
    output rd_addr1, rd_addr2, wr_addr, wr_data, reg_write, dbg_addr,
    input  rd_data1, rd_data2, dbg_data
  );

  modport slave (
    input  rd_addr1, rd_addr2, wr_addr, wr_data, reg_write, dbg_addr,
    output rd_data1, rd_data2, dbg_data
  );
endinterface

`default_nettype wire

// File: rtl/reg_file_8bit.sv
// ----------------------------------------------------------------------------
// reg_file_8bit : 32 x 8 register file, r0 hardwired to zero, write bypass
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module reg_file_8bit #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic            clk,
  input  logic            reset,
  reg_file_8bit_if.slave  bus
);

  localparam int c_DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_regs [c_DEPTH];
  logic [DATA_WIDTH-1:0] w_rd_data1;
  logic [DATA_WIDTH-1:0] w_rd_data2;
  logic [DATA_WIDTH-1:0] w_dbg_data;
  logic                  w_wr_en;

  // Writes to r0 are dropped so r0 only ever holds its reset value.
  assign w_wr_en = bus.reg_write && (bus.wr_addr != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Read priority: reset mask, r0, same-cycle write bypass, array.
  function automatic logic [DATA_WIDTH-1:0] f_read_port(
    input logic                  rst_active,
    input logic [ADDR_WIDTH-1:0] addr,
    input logic                  wr_en,
    input logic [ADDR_WIDTH-1:0] wr_addr,
    input logic [DATA_WIDTH-1:0] wr_data,
    input logic [DATA_WIDTH-1:0] stored
  );
    logic [DATA_WIDTH-1:0] value;
    value = stored;
    if (rst_active || (addr == '0)) begin
      value = '0;
    end else if (wr_en && (wr_addr == addr)) begin
      value = wr_data;
    end
    return value;
  endfunction

  always_comb begin
    w_rd_data1 = '0;
    w_rd_data1 = f_read_port(reset, bus.rd_addr1, w_wr_en, bus.wr_addr,
                             bus.wr_data, r_regs[bus.rd_addr1]);
  end

  always_comb begin
    w_rd_data2 = '0;
    w_rd_data2 = f_read_port(reset, bus.rd_addr2, w_wr_en, bus.wr_addr,
                             bus.wr_data, r_regs[bus.rd_addr2]);
  end

  // Debug view shows raw contents: no bypass and no reset masking.
  always_comb begin
    w_dbg_data = '0;
    if (bus.dbg_addr != '0) begin
      w_dbg_data = r_regs[bus.dbg_addr];
    end
  end

  assign bus.rd_data1 = w_rd_data1;
  assign bus.rd_data2 = w_rd_data2;
  assign bus.dbg_data = w_dbg_data;

endmodule

`default_nettype wire

// File: tb/tb_reg_file_8bit.sv
// ----------------------------------------------------------------------------
// tb_reg_file_8bit : directed self-checking bench for reg_file_8bit
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_reg_file_8bit;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  logic [7:0] preload [32];

  reg_file_8bit_if #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) bus ();

  reg_file_8bit #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then driven mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.reg_write = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
  endtask

  task automatic write(input logic [4:0] a, input logic [7:0] d);
    bus.reg_write = 1'b1;
    bus.wr_addr   = a;
    bus.wr_data   = d;
    tick();
    idle();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    bus.rd_addr1 = '0;
    bus.rd_addr2 = '0;
    bus.dbg_addr = '0;
    idle();
    tick();
    reset = 1'b0;

    // Pre-load every register with a nonzero pattern.
    for (int i = 1; i < 32; i++) begin
      preload[i] = 8'($urandom_range(1, 255));
      write(5'(i), preload[i]);
    end
    bus.dbg_addr = 5'd17; #1;
    check("preload_dbg17", bus.dbg_data, preload[17]);
    bus.rd_addr1 = 5'd3; bus.rd_addr2 = 5'd30; #1;
    check("preload_rd1_r3", bus.rd_data1, preload[3]);
    check("preload_rd2_r30", bus.rd_data2, preload[30]);

    // Reset clears everything; read ports are masked while reset is high.
    reset = 1'b1; #1;
    check("reset_rd1_mask", bus.rd_data1, 8'h00);
    check("reset_rd2_mask", bus.rd_data2, 8'h00);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bus.dbg_addr = 5'(i); #1;
      check($sformatf("reset_dbg_r%0d", i), bus.dbg_data, 8'h00);
    end

    // Basic write then read on both ports and debug.
    write(5'd7, 8'hA5);
    write(5'd31, 8'h3C);
    bus.rd_addr1 = 5'd7; bus.rd_addr2 = 5'd31; bus.dbg_addr = 5'd7; #1;
    check("basic_rd1_r7", bus.rd_data1, 8'hA5);
    check("basic_rd2_r31", bus.rd_data2, 8'h3C);
    check("basic_dbg_r7", bus.dbg_data, 8'hA5);

    // r0 protection.
    bus.reg_write = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 8'hFF;
    bus.rd_addr1 = 5'd0; bus.dbg_addr = 5'd0; #1;
    check("r0_rd1_same", bus.rd_data1, 8'h00);
    check("r0_dbg_same", bus.dbg_data, 8'h00);
    tick();
    idle(); #1;
    check("r0_rd1_next", bus.rd_data1, 8'h00);
    check("r0_dbg_next", bus.dbg_data, 8'h00);

    // Bypass on both ports; debug shows pre-edge contents.
    write(5'd5, 8'h11);
    bus.reg_write = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 8'h99;
    bus.rd_addr1 = 5'd5; bus.rd_addr2 = 5'd5; bus.dbg_addr = 5'd5; #1;
    check("bypass_rd1", bus.rd_data1, 8'h99);
    check("bypass_rd2", bus.rd_data2, 8'h99);
    check("bypass_dbg_before", bus.dbg_data, 8'h11);
    tick();
    idle(); #1;
    check("bypass_dbg_after", bus.dbg_data, 8'h99);
    check("bypass_rd1_after", bus.rd_data1, 8'h99);

    // Ports resolve independently: only port 2 matches the write address.
    bus.reg_write = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 8'h5A;
    bus.rd_addr1 = 5'd5; bus.rd_addr2 = 5'd7; #1;
    check("indep_rd1_r5", bus.rd_data1, 8'h99);
    check("indep_rd2_r7", bus.rd_data2, 8'h5A);
    tick();
    idle();

    // Reset wins over a simultaneous write; debug is not reset-masked.
    reset = 1'b1;
    bus.reg_write = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 8'h42;
    bus.rd_addr1 = 5'd9; bus.rd_addr2 = 5'd5; bus.dbg_addr = 5'd5; #1;
    check("coll_rd1", bus.rd_data1, 8'h00);
    check("coll_rd2", bus.rd_data2, 8'h00);
    check("coll_dbg_r5_before", bus.dbg_data, 8'h99);
    tick();
    reset = 1'b0;
    idle();
    bus.dbg_addr = 5'd9; #1;
    check("coll_dbg_r9", bus.dbg_data, 8'h00);
    check("coll_rd1_r9", bus.rd_data1, 8'h00);
    bus.dbg_addr = 5'd5; #1;
    check("coll_dbg_r5_after", bus.dbg_data, 8'h00);

    // Enable gating: no write and no bypass when reg_write is low.
    write(5'd12, 8'h05);
    bus.reg_write = 1'b0; bus.wr_addr = 5'd12; bus.wr_data = 8'h77;
    bus.rd_addr1 = 5'd12; bus.dbg_addr = 5'd12; #1;
    check("gate_rd1_nobypass", bus.rd_data1, 8'h05);
    tick(); #1;
    check("gate_dbg_r12", bus.dbg_data, 8'h05);
    check("gate_rd1_r12", bus.rd_data1, 8'h05);
    idle();

    // Back-to-back writes to one address: each value bypasses, last one sticks.
    bus.rd_addr1 = 5'd3; bus.dbg_addr = 5'd3;
    for (int k = 1; k <= 3; k++) begin
      bus.reg_write = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 8'(k); #1;
      check($sformatf("b2b_bypass_%0d", k), bus.rd_data1, 8'(k));
      tick();
    end
    idle(); #1;
    check("b2b_dbg_final", bus.dbg_data, 8'h03);
    check("b2b_rd1_final", bus.rd_data1, 8'h03);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reg_file_8bit.md
# reg_file_8bit

Register file for the 8-bit MIPS datapath: 32 × 8-bit general-purpose registers, two combinational read ports, one synchronous write port. The write address comes directly from the 5-bit destination-register mux (rt/rd select) in the write-back path; read addresses come from the decode stage. Register 0 is hardwired to zero, and same-cycle write-to-read bypass removes the write-back/decode hazard.

## Interface
Parameters:
- DATA_WIDTH, 8, register width in bits
- ADDR_WIDTH, 5, register address width; depth = 2**ADDR_WIDTH (32)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; sampled on rising clk
- rd_addr1  input  ADDR_WIDTH  read port 1 address (rs)
- rd_addr2  input  ADDR_WIDTH  read port 2 address (rt)
- rd_data1  output  DATA_WIDTH  read port 1 data
- rd_data2  output  DATA_WIDTH  read port 2 data
- wr_addr  input  ADDR_WIDTH  write address, driven by the destination-register mux output
- wr_data  input  DATA_WIDTH  write data from write-back
- reg_write  input  1  write enable
- dbg_addr  input  ADDR_WIDTH  debug/observation read address
- dbg_data  output  DATA_WIDTH  debug read data (raw array contents, no bypass)

## Operation
- Storage: array regs[0..31], DATA_WIDTH bits each.
- Write: on rising clk, if reset=0, reg_write=1 and wr_addr!=0, then regs[wr_addr] <= wr_data. Writes to address 0 are silently dropped.
- Reset: on rising clk with reset=1, all 32 registers clear to 0. Reset has priority over a simultaneous write; the write is lost.
- Read (per port n, combinational):
  - reset=1 -> rd_data_n = 0
  - rd_addr_n=0 -> 0
  - reg_write=1 and wr_addr=rd_addr_n (nonzero) -> wr_data (bypass)
  - otherwise -> regs[rd_addr_n]
- Both ports may read the same address, and either may match the write address, in the same cycle. Each port resolves independently.
- dbg_data = regs[dbg_addr] with no bypass and no reset masking. Address 0 always reads 0.
- No X propagation: every register has a defined value after the first reset edge.

## Timing
- Write latency: 1 clk. Data is in the array after the rising edge; with bypass it is visible on a matching read port in the same cycle it is presented.
- Read latency: 0 (combinational from rd_addr, wr_addr, wr_data, reg_write, reset).
- Reset values: all regs 0. While reset is high, rd_data1 = rd_data2 = 0. dbg_data reads 0 from the cycle after the reset edge.
- Reset asserted mid-sequence: pending writes in that cycle are discarded. Contents written before reset are cleared on that edge.
- Back-to-back writes to the same address: the last one wins. Each intermediate value is visible via bypass in its own cycle.
- reg_write=0: the array is unchanged regardless of wr_addr and wr_data; no bypass.

## Test plan
- Reset: assert reset for 1 clk after random pre-load -> dbg_data=0x00 for all 32 addresses; rd_data1/2=0x00 while reset is high.
- Basic write/read: write 0xA5 to r7, 0x3C to r31 -> next cycle rd_addr1=7 gives 0xA5, rd_addr2=31 gives 0x3C; dbg_addr=7 gives 0xA5.
- r0 protection: reg_write=1, wr_addr=0, wr_data=0xFF -> rd_data1 (addr 0)=0x00 same and next cycle; dbg_data(0)=0x00.
- Bypass: r5 holds 0x11; present reg_write=1, wr_addr=5, wr_data=0x99 with rd_addr1=rd_addr2=5 -> both read 0x99 in that cycle; dbg_data(5)=0x11 before the edge and 0x99 after.
- Reset vs write collision: reset=1, reg_write=1, wr_addr=9, wr_data=0x42 on the same edge -> r9=0x00 afterwards; rd_data=0 during that cycle.
- Enable gating: reg_write=0, wr_addr=12, wr_data=0x77 with r12=0x05 -> r12 stays 0x05; no bypass on rd_addr1=12.
